serial_hex_loader: RTL and testbench

- Hardware program loader for the yrv_m1 system. Sits between the UART RX/TX byte streams and the CPU program memory.
- Parses ASCII hex text lines (8 hex digits per line), writes 32-bit words into memory, and holds the CPU in reset until a start command arrives.
- Once started, it hands the serial link to the CPU so the hello-world/echo traffic flows unchanged.

---
 rtl/serial_hex_loader_pkg.sv | 45 ++++
 rtl/hex_char_decode.sv | 30 +++
 rtl/serial_hex_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_serial_hex_loader.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_hex_loader_pkg.sv
// Shared types, ASCII constants and the hex digit helper for the serial hex loader.
package serial_hex_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    StLine = 3'd0,
    StData = 3'd1,
    StAddr = 3'd2,
    StSkip = 3'd3,
    StTx   = 3'd4,
    StDone = 3'd5
  } state_e;

  // Classification of one received byte.
  typedef enum logic [2:0] {
    ClsHex     = 3'd0,
    ClsLf      = 3'd1,
    ClsCr      = 3'd2,
    ClsAt      = 3'd3,
    ClsStart   = 3'd4,
    ClsIllegal = 3'd5
  } char_cls_e;

  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_AT      = 8'h40;
  localparam logic [7:0] CH_S       = 8'h53;
  localparam logic [7:0] CH_S_LOWER = 8'h73;

  // Hex digits per data word and maximum digits in an address line.
  localparam logic [3:0] DIGITS_PER_WORD = 4'd8;

  // Returns {valid, nibble}; letters share the low-nibble trick: 'a'/'A' low nibble 1 -> 1+9=10.
  function automatic logic [4:0] hex_nibble(input logic [7:0] ch);
    logic [4:0] res;
    res = 5'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      res = {1'b1, ch[3:0]};
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      res = {1'b1, ch[3:0] + 4'd9};
    end
    return res;
  endfunction

endpackage

// File: rtl/hex_char_decode.sv
// Combinational classifier: maps one received byte to its character class and hex value.
module hex_char_decode
  import serial_hex_loader_pkg::*;
(
  input  logic [7:0] ch_i,
  output char_cls_e  cls_o,
  output logic [3:0] nibble_o
);

  logic [4:0] hex_res;

  // Classify the byte; hex takes priority since no hex digit overlaps the control characters.
  always_comb begin
    hex_res  = hex_nibble(ch_i);
    nibble_o = hex_res[3:0];
    cls_o    = ClsIllegal;
    if (hex_res[4]) begin
      cls_o = ClsHex;
    end else if (ch_i == CH_LF) begin
      cls_o = ClsLf;
    end else if (ch_i == CH_CR) begin
      cls_o = ClsCr;
    end else if (ch_i == CH_AT) begin
      cls_o = ClsAt;
    end else if (ch_i == CH_S || ch_i == CH_S_LOWER) begin
      cls_o = ClsStart;
    end
  end

endmodule

// File: rtl/serial_hex_loader.sv
// Program loader: parses ASCII hex lines from the UART, writes words into program memory and
// keeps the CPU in reset until a start command is acknowledged.
module serial_hex_loader
  import serial_hex_loader_pkg::*;
#(
  parameter int unsigned       MEM_AW     = 12,
  parameter logic [MEM_AW-1:0] START_ADDR = '0,
  parameter logic [7:0]        ACK_CHAR   = 8'h4B,
  parameter logic [7:0]        ERR_CHAR   = 8'h21
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset_p,
  output logic              load_active,
  output logic [15:0]       word_cnt,
  output logic [7:0]        err_cnt
);

  state_e            state_q, state_d;
  logic [31:0]       acc_q, acc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              rx_ready_q, rx_ready_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  char_cls_e         cls;
  logic [3:0]        nibble;
  logic              rx_fire;
  logic              take_err;

  hex_char_decode u_decode (
    .ch_i     (rx_data),
    .cls_o    (cls),
    .nibble_o (nibble)
  );

  // rx_ready is registered, so a byte is only ever offered to a state that can take it.
  assign rx_fire = rx_valid & rx_ready_q;

  // Next-state logic for the line parser, write strobe, transmit byte and counters.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    done_d      = done_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tx_data_d   = tx_data_q;
    word_cnt_d  = word_cnt_q;
    err_cnt_d   = err_cnt_q;
    take_err    = 1'b0;

    unique case (state_q)
      StLine: begin
        if (rx_fire) begin
          case (cls)
            ClsHex: begin
              acc_d   = {28'h0, nibble};
              cnt_d   = 4'd1;
              state_d = StData;
            end
            ClsAt: begin
              acc_d   = 32'h0;
              cnt_d   = 4'd0;
              state_d = StAddr;
            end
            ClsLf, ClsCr: ;
            ClsStart: begin
              tx_data_d = ACK_CHAR;
              done_d    = 1'b1;
              state_d   = StTx;
            end
            default: state_d = StSkip;
          endcase
        end
      end

      StData: begin
        if (rx_fire) begin
          case (cls)
            ClsHex: begin
              if (cnt_q == DIGITS_PER_WORD) begin
                state_d = StSkip;
              end else begin
                acc_d = {acc_q[27:0], nibble};
                cnt_d = cnt_q + 4'd1;
              end
            end
            ClsLf: begin
              if (cnt_q == DIGITS_PER_WORD) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = acc_q;
                addr_d      = addr_q + MEM_AW'(1);
                word_cnt_d  = word_cnt_q + 16'd1;
                state_d     = StLine;
              end else begin
                take_err = 1'b1;
              end
            end
            ClsCr: ;
            default: state_d = StSkip;
          endcase
        end
      end

      StAddr: begin
        if (rx_fire) begin
          case (cls)
            ClsHex: begin
              if (cnt_q == DIGITS_PER_WORD) begin
                state_d = StSkip;
              end else begin
                acc_d = {acc_q[27:0], nibble};
                cnt_d = cnt_q + 4'd1;
              end
            end
            ClsLf: begin
              if (cnt_q != 4'd0) begin
                // Address bits above the memory width are silently dropped.
                addr_d  = acc_q[MEM_AW-1:0];
                state_d = StLine;
              end else begin
                take_err = 1'b1;
              end
            end
            ClsCr: ;
            default: state_d = StSkip;
          endcase
        end
      end

      StSkip: begin
        if (rx_fire && cls == ClsLf) begin
          take_err = 1'b1;
        end
      end

      StTx: begin
        if (tx_ready) begin
          state_d = done_q ? StDone : StLine;
        end
      end

      StDone: ;

      default: state_d = StLine;
    endcase

    // Every rejected line ends here: report it and count it.
    if (take_err) begin
      tx_data_d = ERR_CHAR;
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      state_d   = StTx;
    end

    rx_ready_d = (state_d == StLine) || (state_d == StData) ||
                 (state_d == StAddr) || (state_d == StSkip);
  end

  // FSM state and line parsing registers.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= StLine;
      acc_q      <= 32'h0;
      cnt_q      <= 4'd0;
      addr_q     <= START_ADDR;
      done_q     <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  // Registered memory write port; the strobe lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= START_ADDR;
      mem_wdata_q <= 32'h0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Transmit byte and status counters.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      tx_data_q  <= 8'h0;
      word_cnt_q <= 16'h0;
      err_cnt_q  <= 8'h0;
    end else begin
      tx_data_q  <= tx_data_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_valid    = (state_q == StTx);
  assign tx_data     = tx_data_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_reset_p = (state_q != StDone);
  assign load_active = (state_q != StDone);
  assign word_cnt    = word_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_serial_hex_loader.sv
// Bench for serial_hex_loader: two instances (12-bit and 4-bit address) see identical traffic;
// directed table lines, hand-written start/reset sequences and random lines checked by a
// line-level model.
module tb_serial_hex_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_p  = 1'b1;
  logic [7:0] rx_data  = 8'h0;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_hold  = 1'b0;

  logic        rx_ready_a, tx_valid_a, mem_we_a, cpu_reset_a, load_active_a;
  logic [7:0]  tx_data_a, err_cnt_a;
  logic [11:0] mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic [15:0] word_cnt_a;

  logic        rx_ready_b, tx_valid_b, mem_we_b, cpu_reset_b, load_active_b;
  logic [7:0]  tx_data_b, err_cnt_b;
  logic [3:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [15:0] word_cnt_b;

  serial_hex_loader #(.MEM_AW(12)) u_dut_a (
    .clk(clk), .reset_p(reset_p), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .cpu_reset_p(cpu_reset_a), .load_active(load_active_a), .word_cnt(word_cnt_a),
    .err_cnt(err_cnt_a)
  );

  serial_hex_loader #(.MEM_AW(4)) u_dut_b (
    .clk(clk), .reset_p(reset_p), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .cpu_reset_p(cpu_reset_b), .load_active(load_active_b), .word_cnt(word_cnt_b),
    .err_cnt(err_cnt_b)
  );

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {
    string       text;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  txb;
    int          words;
    int          errs;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  wr_t         wq[$];
  logic [7:0]  txq[$];
  vec_t        tbl[$];
  // Line-level reference state: unbounded address, masked per instance on compare.
  logic [31:0] m_addr;
  int          m_words;
  int          m_errs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0h, expected no such event", name, act);
  endtask

  // Random transmitter back-pressure unless a sequence is holding it off.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitors: tx handshakes and stability, rx_ready during tx, memory writes.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_tx_data = 8'h0;
  wr_t        wexp;
  logic [7:0] texp;
  always @(negedge clk) begin
    if (reset_p) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("tx_hold_valid", 32'(tx_valid_a), 32'd1);
        chk("tx_hold_data", 32'(tx_data_a), 32'(prev_tx_data));
      end
      if (tx_valid_a) chk("rx_ready_in_tx", 32'({rx_ready_a, rx_ready_b}), 32'd0);
      if (tx_valid_a && tx_ready) begin
        if (txq.size() == 0) begin
          fail("unexpected_tx", 32'(tx_data_a));
        end else begin
          texp = txq.pop_front();
          chk("tx_byte_a", 32'(tx_data_a), 32'(texp));
          chk("tx_byte_b", 32'(tx_data_b), 32'(texp));
          chk("tx_valid_b", 32'(tx_valid_b), 32'd1);
          chk("we_during_tx", 32'(mem_we_a), 32'd0);
        end
      end
      prev_stall   = tx_valid_a && !tx_ready;
      prev_tx_data = tx_data_a;
    end
    if (mem_we_a || mem_we_b) begin
      if (wq.size() == 0) begin
        fail("unexpected_write", mem_wdata_a);
      end else begin
        wexp = wq.pop_front();
        chk("we_a", 32'(mem_we_a), 32'd1);
        chk("we_b", 32'(mem_we_b), 32'd1);
        chk("waddr_a", 32'(mem_addr_a), 32'(wexp.addr[11:0]));
        chk("waddr_b", 32'(mem_addr_b), 32'(wexp.addr[3:0]));
        chk("wdata_a", mem_wdata_a, wexp.data);
        chk("wdata_b", mem_wdata_b, wexp.data);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_we_a", 32'(mem_we_a), 0);         chk("rst_we_b", 32'(mem_we_b), 0);
    chk("rst_addr_a", 32'(mem_addr_a), 0);     chk("rst_addr_b", 32'(mem_addr_b), 0);
    chk("rst_wdata_a", mem_wdata_a, 0);        chk("rst_wdata_b", mem_wdata_b, 0);
    chk("rst_txv_a", 32'(tx_valid_a), 0);      chk("rst_txv_b", 32'(tx_valid_b), 0);
    chk("rst_txd_a", 32'(tx_data_a), 0);       chk("rst_txd_b", 32'(tx_data_b), 0);
    chk("rst_cpu_a", 32'(cpu_reset_a), 1);     chk("rst_cpu_b", 32'(cpu_reset_b), 1);
    chk("rst_load_a", 32'(load_active_a), 1);  chk("rst_load_b", 32'(load_active_b), 1);
    chk("rst_words_a", 32'(word_cnt_a), 0);    chk("rst_words_b", 32'(word_cnt_b), 0);
    chk("rst_errs_a", 32'(err_cnt_a), 0);      chk("rst_errs_b", 32'(err_cnt_b), 0);
    chk("rst_rxr_a", 32'(rx_ready_a), 0);      chk("rst_rxr_b", 32'(rx_ready_b), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_p  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    wq.delete();
    txq.delete();
    @(posedge clk); #1;
    reset_p = 1'b0;
    @(negedge clk);
    chk("rxr_at_release", 32'(rx_ready_a), 0);
    @(negedge clk);
    chk("rxr_after_release_a", 32'(rx_ready_a), 1);
    chk("rxr_after_release_b", 32'(rx_ready_b), 1);
    m_addr  = 32'h0;
    m_words = 0;
    m_errs  = 0;
  endtask

  // Presents one byte and returns at posedge+1 after it was taken; rx_valid stays high.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("rx_timeout", 32'(b));
    @(posedge clk); #1;
  endtask

  task automatic send_line(input string s);
    @(posedge clk); #1;
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((txq.size() != 0 || wq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("drain_timeout", 32'(txq.size() + wq.size()));
    @(negedge clk);
  endtask

  task automatic run_line(input int idx, input string s, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [7:0] txb, input int words,
                          input int errs);
    if (wr) wq.push_back({addr, data});
    if (txb != 8'h0) txq.push_back(txb);
    send_line(s);
    drain();
    chk($sformatf("words_a[%0d]", idx), 32'(word_cnt_a), 32'(words & 16'hFFFF));
    chk($sformatf("words_b[%0d]", idx), 32'(word_cnt_b), 32'(words & 16'hFFFF));
    chk($sformatf("errs_a[%0d]", idx), 32'(err_cnt_a), 32'(errs));
    chk($sformatf("errs_b[%0d]", idx), 32'(err_cnt_b), 32'(errs));
  endtask

  task automatic add(input string t, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] txb, input int w, input int e);
    vec_t v;
    v.text = t; v.wr = wr; v.addr = a; v.data = d; v.txb = txb; v.words = w; v.errs = e;
    tbl.push_back(v);
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Reference: judge a whole line by its text (CRs removed), then update model state.
  task automatic model_line(input string s, output bit wr, output logic [31:0] addr,
                            output logic [31:0] data, output logic [7:0] txb);
    string       t = "";
    bit          ok;
    logic [31:0] v = 32'h0;
    int          first;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] != 8'h0D && s[i] != 8'h0A) t = {t, $sformatf("%c", s[i])};
    end
    wr = 1'b0; addr = 32'h0; data = 32'h0; txb = 8'h0;
    if (t.len() == 0) return;
    first = (t[0] == "@") ? 1 : 0;
    ok = first ? (t.len() >= 2 && t.len() <= 9) : (t.len() == 8);
    for (int i = first; i < t.len(); i++) begin
      if (hexval(t[i]) < 0) ok = 1'b0;
      else v = (v << 4) | 32'(hexval(t[i]));
    end
    if (!ok) begin
      m_errs = (m_errs < 255) ? m_errs + 1 : 255;
      txb = 8'h21;
    end else if (first == 1) begin
      m_addr = v;
    end else begin
      wr = 1'b1; addr = m_addr; data = v;
      m_addr = m_addr + 32'd1;
      m_words++;
    end
  endtask

  function automatic string add_ch(input string s, input logic [7:0] c);
    string r = s;
    if ($urandom_range(0, 9) == 0) r = {r, "\r"};
    return {r, $sformatf("%c", c)};
  endfunction

  function automatic string rand_hex(input int n);
    string hexs = "0123456789abcdefABCDEF";
    string s = "";
    for (int i = 0; i < n; i++) s = add_ch(s, hexs[$urandom_range(0, 21)]);
    return s;
  endfunction

  function automatic string gen_line();
    string      ills = "Gz# .x@~";
    string      s = "";
    int         n;
    logic [7:0] c;
    case ($urandom_range(0, 7))
      0, 1, 2: s = rand_hex(8);
      3: s = {add_ch("", "@"), rand_hex($urandom_range(1, 8))};
      4: begin
        n = $urandom_range(0, 12);
        if (n == 8) n = 9;
        s = rand_hex(n);
      end
      5: s = {add_ch("", "@"), rand_hex(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 11))};
      6: begin
        n = $urandom_range(0, 7);
        s = {rand_hex(n), add_ch("", ills[$urandom_range(0, 7)]), rand_hex(7 - n)};
      end
      default: begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
          do c = 8'($urandom_range(1, 255));
          while (c == 8'h0A || c == 8'h53 || c == 8'h73);
          s = add_ch(s, c);
        end
      end
    endcase
    return {s, "\n"};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr;
    logic [31:0] a, d;
    logic [7:0]  txb;
    string       s;
    int          n;

    // Directed lines: expected effects worked out by hand from the loader rules.
    add("12G4\n",         0, 32'h0,    32'h0,        8'h21, 0, 1);
    add("0000000A\n",     1, 32'h0,    32'h0000000A, 8'h00, 1, 1);
    add("123456789\n",    0, 32'h0,    32'h0,        8'h21, 1, 2);
    add("1234\n",         0, 32'h0,    32'h0,        8'h21, 1, 3);
    add("@\n",            0, 32'h0,    32'h0,        8'h21, 1, 4);
    add("00000093\n",     1, 32'h1,    32'h00000093, 8'h00, 2, 4);
    add("DEADBEEF\n",     1, 32'h2,    32'hDEADBEEF, 8'h00, 3, 4);
    add("@00000010\r\n",  0, 32'h0,    32'h0,        8'h00, 3, 4);
    add("cafef00d\r\n",   1, 32'h10,   32'hCAFEF00D, 8'h00, 4, 4);
    add("\r\n",           0, 32'h0,    32'h0,        8'h00, 4, 4);
    add("@fff\n",         0, 32'h0,    32'h0,        8'h00, 4, 4);
    add("11111111\n",     1, 32'hFFF,  32'h11111111, 8'h00, 5, 4);
    add("22222222\n",     1, 32'h1000, 32'h22222222, 8'h00, 6, 4);
    add("@1\rS\n",        0, 32'h0,    32'h0,        8'h21, 6, 5);
    add("0\n",            0, 32'h0,    32'h0,        8'h21, 6, 6);
    add("@123456789A\n",  0, 32'h0,    32'h0,        8'h21, 6, 7);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      run_line(i, tbl[i].text, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].txb,
               tbl[i].words, tbl[i].errs);
    end

    // Start command with the transmitter stalled for 20 cycles.
    tx_hold = 1'b1;
    txq.push_back(8'h4B);
    @(posedge clk); #1;
    send_byte("S");
    rx_data = 8'h0A;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ack_valid", 32'(tx_valid_a), 1);
      chk("ack_data", 32'(tx_data_a), 32'h4B);
      chk("ack_rxr", 32'(rx_ready_a), 0);
      chk("ack_cpu_reset", 32'(cpu_reset_a), 1);
    end
    tx_hold = 1'b0;
    n = 0;
    while (!(tx_valid_a && tx_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("ack_timeout", 32'(tx_valid_a));
    @(negedge clk);
    chk("done_cpu_a", 32'(cpu_reset_a), 0);     chk("done_cpu_b", 32'(cpu_reset_b), 0);
    chk("done_load_a", 32'(load_active_a), 0);  chk("done_load_b", 32'(load_active_b), 0);
    chk("done_rxr", 32'(rx_ready_a), 0);        chk("done_txv", 32'(tx_valid_a), 0);
    repeat (5) @(negedge clk);
    chk("done_stays", 32'(load_active_a), 0);
    chk("done_words", 32'(word_cnt_a), 6);
    chk("ack_drained", 32'(txq.size()), 0);
    rx_valid = 1'b0;

    // Address wrap on the narrow instance, then reset in the middle of a line.
    do_reset();
    run_line(100, "@F\n",       0, 32'h0,  32'h0,        8'h00, 0, 0);
    run_line(101, "AAAAAAAA\n", 1, 32'hF,  32'hAAAAAAAA, 8'h00, 1, 0);
    run_line(102, "BBBBBBBB\n", 1, 32'h10, 32'hBBBBBBBB, 8'h00, 2, 0);
    @(posedge clk); #1;
    send_byte("1"); send_byte("2"); send_byte("3"); send_byte("4");
    do_reset();
    run_line(103, "55555555\n", 1, 32'h0,  32'h55555555, 8'h00, 1, 0);

    // Reset while an error byte is waiting on the transmitter: the byte is dropped.
    tx_hold = 1'b1;
    send_line("zz\n");
    repeat (3) @(negedge clk);
    chk("pending_err_valid", 32'(tx_valid_a), 1);
    chk("pending_err_data", 32'(tx_data_a), 32'h21);
    do_reset();
    tx_hold = 1'b0;

    // Random lines against the line-level model.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      s = gen_line();
      model_line(s, wr, a, d, txb);
      run_line(200 + i, s, wr, a, d, txb, m_words, m_errs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
